// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchronised rx input, mid-bit sampling FSM, and a
// first-word-fall-through receive FIFO with sticky frame/overrun flags.
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          rx_empty,
   output logic                          rx_full,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr
);

   localparam int DIVISOR = CLK_FREQ / BAUD;
   localparam int CW      = $clog2(DIVISOR);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e        state_q, state_d;
   logic          rx_meta_q, rx_s_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          tick, push, frame_set;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
   logic          do_pop, do_push, ovr_set;

   assign tick = (cnt_q == '0);

   // Receive FSM: counter reloads on every state entry, tick marks the sample point.
   always_comb begin
      state_d   = state_q;
      cnt_d     = tick ? cnt_q : cnt_q - CW'(1);
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      push      = 1'b0;
      frame_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d = S_START;
               cnt_d   = HALF_LOAD;
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  bit_idx_d = 3'd0;
                  cnt_d     = FULL_LOAD;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shreg_d[bit_idx_q] = rx_s_q;
               cnt_d              = FULL_LOAD;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         S_STOP: begin
            if (tick) begin
               state_d = S_IDLE;
               if (rx_s_q) push = 1'b1;
               else        frame_set = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A pop in the same cycle frees the slot, so a push at full still lands.
   always_comb begin
      do_pop   = rd_en && (count_q != '0);
      do_push  = push && ((count_q != DEPTH_CNT) || do_pop);
      ovr_set  = push && (count_q == DEPTH_CNT) && !do_pop;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = shreg_q;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW + 1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW + 1)'(1);
      frame_err_d = (frame_err_q && !err_clr) || frame_set;
      overrun_d   = (overrun_q && !err_clr) || ovr_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rx_meta_q   <= rx;
         rx_s_q      <= rx_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         mem_q       <= mem_d;
      end
   end

   assign rd_data   = mem_q[rd_ptr_q];
   assign rx_empty  = (count_q == '0);
   assign rx_full   = (count_q == DEPTH_CNT);
   assign rx_count  = count_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives serial frames on rx and compares the FIFO
// and flag outputs against a queue-based model of received bytes.
module tb_uart_rx_fifo;

   localparam int DIV   = 10;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst, rx, rd_en, err_clr;
   logic [7:0] rd_data;
   logic       rx_empty, rx_full, frame_err, overrun;
   logic [4:0] rx_count;

   logic [7:0] exp_q[$];
   logic       exp_ferr, exp_ovr;
   int         errors = 0;
   int         checks = 0;

   uart_rx_fifo #(
      .CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
      .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
      .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Observed status: {empty, full, count, frame_err, overrun, head (masked when empty)}
   wire [16:0] dut_status = {rx_empty, rx_full, rx_count, frame_err, overrun,
                             (rx_empty ? 8'h00 : rd_data)};

   function automatic logic [16:0] exp_status();
      int         n;
      logic [7:0] head;
      n    = exp_q.size();
      head = (n > 0) ? exp_q[0] : 8'h00;
      return {(n == 0), (n == DEPTH), 5'(n), exp_ferr, exp_ovr, head};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One 8N1 frame; optional pop during the stop-sample cycle, optional reset mid data bit.
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input bit pop_at_stop, input int rst_bit);
      rx = 1'b0;
      step(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == rst_bit) begin
            step(5); rst = 1'b1; step(1); rst = 1'b0; step(DIV - 6);
         end else begin
            step(DIV);
         end
      end
      rx = stop;
      if (pop_at_stop) begin
         step(7); rd_en = 1'b1; step(1); rd_en = 1'b0; step(2);
      end else begin
         step(DIV);
      end
      rx = 1'b1;
      if (rst_bit >= 0) begin
         exp_q.delete();
         exp_ferr = 1'b0;
         exp_ovr  = 1'b0;
      end else begin
         if (pop_at_stop && exp_q.size() > 0) void'(exp_q.pop_front());
         if (!stop)                      exp_ferr = 1'b1;
         else if (exp_q.size() == DEPTH) exp_ovr  = 1'b1;
         else                            exp_q.push_back(b);
      end
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic clear_flags();
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      checks++;
      if ({rx_empty, rx_full, rx_count, frame_err, overrun, rd_data} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset: got e=%b f=%b cnt=%0d fe=%b ov=%b rd=%h, want 1 0 0 0 0 00",
                  rx_empty, rx_full, rx_count, frame_err, overrun, rd_data);
      end
   endtask

   task automatic test_single();
      send_frame(8'h55, 1'b1, 1'b0, -1);
      checks++;
      if ({rx_count, rd_data, frame_err} !== {5'd1, 8'h55, 1'b0}) begin
         errors++;
         $display("FAIL single: got cnt=%0d rd=%h fe=%b, want 1 55 0", rx_count, rd_data, frame_err);
      end
      pop_one();
      checks++;
      if (rx_empty !== 1'b1) begin
         errors++;
         $display("FAIL single_pop: got empty=%b, want 1", rx_empty);
      end
      // Push into an empty FIFO while rd_en is high: the pop is ignored.
      send_frame(8'h9B, 1'b1, 1'b1, -1);
      checks++;
      if ({rx_count, rd_data} !== {5'd1, 8'h9B}) begin
         errors++;
         $display("FAIL empty_pop_push: got cnt=%0d rd=%h, want 1 9b", rx_count, rd_data);
      end
      pop_one();
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      step(3);
      rx = 1'b1;
      step(20);
      checks++;
      if ({rx_count, frame_err, overrun} !== {5'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL glitch: got cnt=%0d fe=%b ov=%b, want 0 0 0", rx_count, frame_err, overrun);
      end
      send_frame(8'hC3, 1'b1, 1'b0, -1);
      checks++;
      if ({rx_count, rd_data} !== {5'd1, 8'hC3}) begin
         errors++;
         $display("FAIL glitch_next: got cnt=%0d rd=%h, want 1 c3", rx_count, rd_data);
      end
      pop_one();
   endtask

   task automatic test_frame_err();
      send_frame(8'hA3, 1'b0, 1'b0, -1);
      step(3);
      checks++;
      if ({frame_err, rx_count} !== {1'b1, 5'd0}) begin
         errors++;
         $display("FAIL frame_err: got fe=%b cnt=%0d, want 1 0", frame_err, rx_count);
      end
      clear_flags();
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL frame_err_clr: got fe=%b, want 0", frame_err);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i <= 16; i++) begin
         send_frame(8'(i), 1'b1, 1'b0, -1);
         step(2);
      end
      checks++;
      if ({rx_full, rx_count, overrun} !== {1'b1, 5'd16, 1'b1}) begin
         errors++;
         $display("FAIL overflow: got full=%b cnt=%0d ov=%b, want 1 16 1", rx_full, rx_count, overrun);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rd_data !== 8'(i)) begin
            errors++;
            $display("FAIL overflow_order: got rd=%h, want %h", rd_data, 8'(i));
         end
         pop_one();
      end
      checks++;
      if (rx_empty !== 1'b1) begin
         errors++;
         $display("FAIL overflow_drain: got empty=%b, want 1", rx_empty);
      end
      clear_flags();
   endtask

   task automatic test_back_to_back();
      send_frame(8'h12, 1'b1, 1'b0, -1);
      send_frame(8'h34, 1'b1, 1'b0, -1);
      checks++;
      if ({rx_count, rd_data} !== {5'd2, 8'h12}) begin
         errors++;
         $display("FAIL b2b: got cnt=%0d rd=%h, want 2 12", rx_count, rd_data);
      end
      for (int i = 0; i < 14; i++) send_frame(8'(8'h40 + i), 1'b1, 1'b0, -1);
      send_frame(8'hEE, 1'b1, 1'b1, -1);
      checks++;
      if ({rx_count, overrun, rd_data} !== {5'd16, 1'b0, 8'h34}) begin
         errors++;
         $display("FAIL full_pop_push: got cnt=%0d ov=%b rd=%h, want 16 0 34", rx_count, overrun, rd_data);
      end
      while (exp_q.size() > 0) begin
         checks++;
         if (dut_status !== exp_status()) begin
            errors++;
            $display("FAIL b2b_drain: got %h, want %h", dut_status, exp_status());
         end
         pop_one();
      end
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'h11, 1'b1, 1'b0, -1);
      send_frame(8'h5A, 1'b0, 1'b0, -1);
      send_frame(8'hFF, 1'b1, 1'b0, 4);
      checks++;
      if ({rx_empty, rx_full, rx_count, frame_err, overrun, rd_data} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL rst_mid: got e=%b f=%b cnt=%0d fe=%b ov=%b rd=%h, want 1 0 0 0 0 00",
                  rx_empty, rx_full, rx_count, frame_err, overrun, rd_data);
      end
      send_frame(8'h7E, 1'b1, 1'b0, -1);
      checks++;
      if ({rd_data, rx_count} !== {8'h7E, 5'd1}) begin
         errors++;
         $display("FAIL rst_next: got rd=%h cnt=%0d, want 7e 1", rd_data, rx_count);
      end
      pop_one();
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) == 0), -1);
         step($urandom_range(0, 12));
         checks++;
         if (dut_status !== exp_status()) begin
            errors++;
            $display("FAIL random_frame %0d: got %h, want %h", n, dut_status, exp_status());
         end
         for (int p = $urandom_range(0, 2); p > 0; p--) begin
            pop_one();
            checks++;
            if (dut_status !== exp_status()) begin
               errors++;
               $display("FAIL random_pop %0d: got %h, want %h", n, dut_status, exp_status());
            end
         end
         if ($urandom_range(0, 5) == 0) clear_flags();
      end
   endtask

   initial begin
      rst = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
      exp_ferr = 1'b0; exp_ovr = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_overflow();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
